hp_manager: RTL and testbench
=============================

Name: hp_manager

Overview:
- Player hit-point manager, directly downstream of the collision checker.
- Consumes the checker's level-type `collision` output and decrements HP once per rising edge.
- Runs an invulnerability/blink window after each hit and declares game over at zero HP.
- Feeds the HUD (hp, flash) and the top-level game FSM (game_over, hit_pulse).

Parameters:
- HP_MAX, 5, HP value loaded at reset and on restart (must be ≥1).
- HP_W, 3, width of the hp output (must hold HP_MAX).
- CNT_W, 24, width of the invulnerability and blink counters.
- FLASH_CYCLES, 12000000, length of the invulnerability window in clk cycles (≥2).
- FLASH_TOGGLE, 1000000, clk cycles per flash half-period (≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- collision  input  1  level from the collision checker, synchronous to clk.
- heal  input  1  one-cycle pickup pulse, +1 HP.
- restart  input  1  one-cycle pulse, restore full HP and leave any state.
- hp  output  HP_W  current hit points, registered.
- hit_pulse  output  1  high for exactly one cycle per accepted hit, registered.
- flash  output  1  sprite blink enable during invulnerability, registered.
- game_over  output  1  high while in DEAD, registered.

Behaviour:
- Reset (async, rst=1):
  - hp=HP_MAX, state=ALIVE, hit_pulse=0, flash=0, game_over=0.
  - collision_d=0; both counters=0.
- Edge detect:
  - col_rise = collision & ~collision_d.
  - collision_d <= collision every cycle, in every state.
  - A level held high never produces a second hit; a new 0→1 transition is required.
- Latency: col_rise at edge N → hp/hit_pulse/state updated at edge N (visible in cycle N+1). hit_pulse clears at edge N+1.
- States: ALIVE, HIT, DEAD. Priority within any cycle: restart > col_rise > heal.
- ALIVE:
  - col_rise and hp>1: hp<=hp-1, hit_pulse<=1, inv_cnt<=FLASH_CYCLES-1, tog_cnt<=0, flash<=1, go HIT.
  - col_rise and hp==1: hp<=0, hit_pulse<=1, game_over<=1, flash<=0, go DEAD.
  - heal (no col_rise): hp<=min(hp+1, HP_MAX), saturating; no wrap.
- HIT (invulnerable):
  - col_rise ignored: no hp change, no hit_pulse.
  - heal applies as in ALIVE.
  - tog_cnt increments each cycle; at FLASH_TOGGLE-1 it wraps to 0 and flash inverts.
  - inv_cnt decrements each cycle; when inv_cnt==0, next edge goes ALIVE with flash<=0. HIT occupies exactly FLASH_CYCLES cycles.
- DEAD:
  - hp=0, game_over=1, flash=0.
  - col_rise and heal ignored.
  - Only restart leaves DEAD.
- restart (any state):
  - hp<=HP_MAX, state<=ALIVE, flash<=0, game_over<=0, hit_pulse<=0, counters<=0.
  - collision_d still samples collision, so a collision held high through restart does not hit.
- Simultaneous events:
  - col_rise+heal in ALIVE: hit taken, heal dropped.
  - col_rise+restart: restart wins, no hit_pulse.
  - inv_cnt expiry coinciding with col_rise: the hit is ignored (still HIT that cycle).
- Reset mid-HIT or mid-DEAD returns to the full reset values immediately.
- hp never underflows below 0 and never exceeds HP_MAX.

Test Plan (HP_MAX=3, FLASH_CYCLES=20, FLASH_TOGGLE=4):
- Reset then single collision 0→1 held high 50 cycles:
  - hp 3→2 one cycle after the edge, with a single hit_pulse.
  - flash toggles every 4 cycles for 20 cycles, then returns to 0.
  - The held level causes no second hit.
- Second rising edge 5 cycles into HIT → hp unchanged, no hit_pulse; a new edge after HIT expires → hp 2→1.
- Three separated hits → hp 3,2,1,0; game_over=1 on the third; further edges and heal ignored; restart pulse → hp=3, game_over=0, ALIVE.
- heal at hp=3 → stays 3; after one hit, heal → hp 2→3.
- heal and col_rise in the same cycle at hp=2 → hp=1, hit_pulse=1.
- Assert rst mid-HIT (flash=1, hp=1) → hp=3, flash=0, game_over=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/hp_manager.sv
// Player hit-point manager: edge-detected hits, invulnerability blink window,
// heal/restart handling and game-over detection for the HUD and game FSM.
module hp_manager #(
  parameter int unsigned HP_MAX       = 5,
  parameter int unsigned HP_W         = 3,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned FLASH_CYCLES = 12000000,
  parameter int unsigned FLASH_TOGGLE = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            collision,
  input  logic            heal,
  input  logic            restart,
  output logic [HP_W-1:0] hp,
  output logic            hit_pulse,
  output logic            flash,
  output logic            game_over
);

  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

  localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);
  localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOG_LAST = CNT_W'(FLASH_TOGGLE - 1);

  state_t           state, state_n;
  logic [HP_W-1:0]  hp_n, hp_healed;
  logic             hit_pulse_n, flash_n, game_over_n;
  logic             collision_d, col_rise;
  logic [CNT_W-1:0] inv_cnt, inv_cnt_n, tog_cnt, tog_cnt_n;

  assign col_rise  = collision & ~collision_d;
  assign hp_healed = (hp < HP_FULL) ? hp + HP_ONE : hp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ALIVE;
      hp          <= HP_FULL;
      hit_pulse   <= 1'b0;
      flash       <= 1'b0;
      game_over   <= 1'b0;
      collision_d <= 1'b0;
      inv_cnt     <= '0;
      tog_cnt     <= '0;
    end else begin
      state       <= state_n;
      hp          <= hp_n;
      hit_pulse   <= hit_pulse_n;
      flash       <= flash_n;
      game_over   <= game_over_n;
      collision_d <= collision;
      inv_cnt     <= inv_cnt_n;
      tog_cnt     <= tog_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    hp_n        = hp;
    hit_pulse_n = 1'b0;
    flash_n     = flash;
    game_over_n = game_over;
    inv_cnt_n   = inv_cnt;
    tog_cnt_n   = tog_cnt;

    if (restart) begin
      state_n     = ALIVE;
      hp_n        = HP_FULL;
      flash_n     = 1'b0;
      game_over_n = 1'b0;
      inv_cnt_n   = '0;
      tog_cnt_n   = '0;
    end else begin
      unique case (state)
        ALIVE: begin
          if (col_rise) begin
            hit_pulse_n = 1'b1;
            if (hp > HP_ONE) begin
              hp_n      = hp - HP_ONE;
              inv_cnt_n = INV_LOAD;
              tog_cnt_n = '0;
              flash_n   = 1'b1;
              state_n   = HIT;
            end else begin
              hp_n        = '0;
              game_over_n = 1'b1;
              flash_n     = 1'b0;
              state_n     = DEAD;
            end
          end else if (heal) begin
            hp_n = hp_healed;
          end
        end
        HIT: begin
          if (heal) hp_n = hp_healed;
          if (tog_cnt == TOG_LAST) begin
            tog_cnt_n = '0;
            flash_n   = ~flash;
          end else begin
            tog_cnt_n = tog_cnt + 1'b1;
          end
          // Expiry overrides the blink toggle so the sprite always ends visible-off.
          if (inv_cnt == '0) begin
            state_n   = ALIVE;
            flash_n   = 1'b0;
            tog_cnt_n = '0;
          end else begin
            inv_cnt_n = inv_cnt - 1'b1;
          end
        end
        DEAD: begin
          hp_n        = '0;
          game_over_n = 1'b1;
          flash_n     = 1'b0;
        end
        default: state_n = ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp_manager.sv
// Directed bench for hp_manager with HP_MAX=3, FLASH_CYCLES=20, FLASH_TOGGLE=4.
module tb_hp_manager;

  logic       clk = 1'b0;
  logic       rst, collision, heal, restart;
  logic [2:0] hp;
  logic       hit_pulse, flash, game_over;
  int         tests = 0;
  int         fails = 0;

  hp_manager #(
    .HP_MAX(3), .HP_W(3), .CNT_W(8), .FLASH_CYCLES(20), .FLASH_TOGGLE(4)
  ) dut (
    .clk(clk), .rst(rst), .collision(collision), .heal(heal), .restart(restart),
    .hp(hp), .hit_pulse(hit_pulse), .flash(flash), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // Rising edge on collision, observed one cycle later, then collision dropped.
  task automatic hit_once();
    collision = 1'b1;
    tick();
    collision = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; collision = 1'b0; heal = 1'b0; restart = 1'b0;
    tick();
    tests++;
    if (hp !== 3'd3 || hit_pulse !== 1'b0 || flash !== 1'b0 || game_over !== 1'b0) begin
      fails++;
      $display("FAIL reset: hp=%0d hit=%b flash=%b go=%b, need hp=3 hit=0 flash=0 go=0",
               hp, hit_pulse, flash, game_over);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_hit();
    logic exp_flash;
    collision = 1'b1;
    tick();
    tests++;
    if (hp !== 3'd2 || hit_pulse !== 1'b1 || flash !== 1'b1) begin
      fails++;
      $display("FAIL single_hit_first: hp=%0d hit=%b flash=%b, need 2 1 1", hp, hit_pulse, flash);
    end
    for (int k = 1; k < 50; k++) begin
      tick();
      exp_flash = (k < 20) && (((k / 4) % 2) == 0);
      tests++;
      if (hp !== 3'd2 || hit_pulse !== 1'b0 || flash !== exp_flash) begin
        fails++;
        $display("FAIL single_hit_cycle%0d: hp=%0d hit=%b flash=%b, need 2 0 %b",
                 k, hp, hit_pulse, flash, exp_flash);
      end
    end
    collision = 1'b0;
    tick();
  endtask

  task automatic test_rehit_in_hit();
    do_restart();
    hit_once();
    repeat (4) tick();
    collision = 1'b1;
    tick();
    tests++;
    if (hp !== 3'd2 || hit_pulse !== 1'b0) begin
      fails++;
      $display("FAIL rehit_ignored: hp=%0d hit=%b, need 2 0", hp, hit_pulse);
    end
    collision = 1'b0;
    repeat (20) tick();
    tests++;
    if (flash !== 1'b0) begin
      fails++;
      $display("FAIL rehit_expired_flash: flash=%b, need 0", flash);
    end
    collision = 1'b1;
    tick();
    tests++;
    if (hp !== 3'd1 || hit_pulse !== 1'b1) begin
      fails++;
      $display("FAIL rehit_after_expiry: hp=%0d hit=%b, need 1 1", hp, hit_pulse);
    end
    collision = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_expiry_edge();
    do_restart();
    hit_once();
    repeat (19) tick();
    tests++;
    if (flash !== 1'b1) begin
      fails++;
      $display("FAIL expiry_last_hit_cycle_flash: flash=%b, need 1", flash);
    end
    collision = 1'b1;
    tick();
    tests++;
    if (hp !== 3'd2 || hit_pulse !== 1'b0 || flash !== 1'b0) begin
      fails++;
      $display("FAIL expiry_coincident_hit: hp=%0d hit=%b flash=%b, need 2 0 0", hp, hit_pulse, flash);
    end
    collision = 1'b0;
    tick();
    collision = 1'b1;
    tick();
    tests++;
    if (hp !== 3'd1 || hit_pulse !== 1'b1) begin
      fails++;
      $display("FAIL expiry_then_alive_hit: hp=%0d hit=%b, need 1 1", hp, hit_pulse);
    end
    collision = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_death();
    do_restart();
    for (int i = 0; i < 3; i++) begin
      hit_once();
      tests++;
      if (hp !== 3'(2 - i) || hit_pulse !== 1'b1 || game_over !== (i == 2) || flash !== (i != 2)) begin
        fails++;
        $display("FAIL death_hit%0d: hp=%0d hit=%b go=%b flash=%b, need hp=%0d hit=1 go=%b flash=%b",
                 i, hp, hit_pulse, game_over, flash, 2 - i, (i == 2), (i != 2));
      end
      repeat (25) tick();
    end
    collision = 1'b1; heal = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    heal = 1'b0;
    tests++;
    if (hp !== 3'd0 || hit_pulse !== 1'b0 || game_over !== 1'b1 || flash !== 1'b0) begin
      fails++;
      $display("FAIL dead_ignores: hp=%0d hit=%b go=%b flash=%b, need 0 0 1 0",
               hp, hit_pulse, game_over, flash);
    end
    do_restart();
    tests++;
    if (hp !== 3'd3 || game_over !== 1'b0 || flash !== 1'b0) begin
      fails++;
      $display("FAIL dead_restart: hp=%0d go=%b flash=%b, need 3 0 0", hp, game_over, flash);
    end
    hit_once();
    tests++;
    if (hp !== 3'd2 || hit_pulse !== 1'b1) begin
      fails++;
      $display("FAIL restart_alive_hit: hp=%0d hit=%b, need 2 1", hp, hit_pulse);
    end
    repeat (25) tick();
  endtask

  task automatic test_heal();
    do_restart();
    heal = 1'b1;
    tick();
    heal = 1'b0;
    tests++;
    if (hp !== 3'd3) begin
      fails++;
      $display("FAIL heal_saturate: hp=%0d, need 3", hp);
    end
    hit_once();
    heal = 1'b1;
    tick();
    heal = 1'b0;
    tests++;
    if (hp !== 3'd3 || flash !== 1'b1) begin
      fails++;
      $display("FAIL heal_in_hit: hp=%0d flash=%b, need 3 1", hp, flash);
    end
    repeat (25) tick();
  endtask

  task automatic test_simultaneous();
    do_restart();
    hit_once();
    repeat (25) tick();
    collision = 1'b1; heal = 1'b1;
    tick();
    collision = 1'b0; heal = 1'b0;
    tests++;
    if (hp !== 3'd1 || hit_pulse !== 1'b1) begin
      fails++;
      $display("FAIL hit_beats_heal: hp=%0d hit=%b, need 1 1", hp, hit_pulse);
    end
    repeat (25) tick();
    collision = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    tests++;
    if (hp !== 3'd3 || hit_pulse !== 1'b0 || flash !== 1'b0) begin
      fails++;
      $display("FAIL restart_beats_hit: hp=%0d hit=%b flash=%b, need 3 0 0", hp, hit_pulse, flash);
    end
    tick();
    tests++;
    if (hp !== 3'd3 || hit_pulse !== 1'b0) begin
      fails++;
      $display("FAIL held_through_restart: hp=%0d hit=%b, need 3 0", hp, hit_pulse);
    end
    collision = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_restart();
    hit_once();
    repeat (25) tick();
    hit_once();
    tests++;
    if (hp !== 3'd1 || flash !== 1'b1) begin
      fails++;
      $display("FAIL pre_async_reset: hp=%0d flash=%b, need 1 1", hp, flash);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (hp !== 3'd3 || flash !== 1'b0 || game_over !== 1'b0 || hit_pulse !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: hp=%0d flash=%b go=%b hit=%b, need 3 0 0 0",
               hp, flash, game_over, hit_pulse);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_rehit_in_hit();
    test_expiry_edge();
    test_death();
    test_heal();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
